// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the pipeline, between the ALU stage and write-back.
// Executes loads and stores against a private 256 x 64-bit data memory and
// presents a registered result to write-back.
//
// Build option:
//   MEM_STAGE_WAIT_EN  - when defined, loads/stores take MEM_LATENCY cycles.
//                        An IDLE/WAIT FSM holds the upstream pipeline via
//                        stall_out while the access is in flight. When
//                        undefined, every op completes in one cycle and
//                        stall_out is tied low.
//
// Parameters:
//   MEM_LATENCY            cycles per load/store with MEM_STAGE_WAIT_EN (1..15)
//
// Ports:
//   clk                    pipeline clock, rising edge
//   rst_n                  asynchronous active-low reset
//   control_signals_in     [2:0] ALU op, [3] branch, [4] mem_read,
//                          [5] mem_write, [6] reg_write, [7] jump
//   value_in               ALU result / store data
//   address_in             data-memory word address
//   reg_to_be_written_in   destination register index
//   control_signals_out    registered control byte (0 while stalled)
//   value_out              load data for loads, value_in otherwise
//   reg_to_be_written_out  registered destination register
//   reg_write_en           registered reg_write of the completing op
//   stall_out              upstream must hold its inputs while high
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int MEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  control_signals_in,
    input  logic [63:0] value_in,
    input  logic [7:0]  address_in,
    input  logic [3:0]  reg_to_be_written_in,
    output logic [7:0]  control_signals_out,
    output logic [63:0] value_out,
    output logic [3:0]  reg_to_be_written_out,
    output logic        reg_write_en,
    output logic        stall_out
);

    generate
        if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
            $error("mem_stage: MEM_LATENCY must be in the range 1..15");
        end
    endgenerate

    // Data memory; contents are deliberately not reset.
    logic [63:0] r_mem [0:255];

    // The op being committed this cycle (live inputs or holding registers).
    logic [7:0]  w_op_ctrl;
    logic [63:0] w_op_value;
    logic [7:0]  w_op_addr;
    logic [3:0]  w_op_reg;
    logic        w_commit;

`ifdef MEM_STAGE_WAIT_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam bit         MULTI_CYCLE = (MEM_LATENCY > 1);
    // Counter starts at latency-2 so the commit lands on edge E+N-1.
    localparam logic [3:0] CNT_LOAD    = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [7:0]  r_hold_ctrl;
    logic [7:0]  w_hold_ctrl_nxt;
    logic [63:0] r_hold_value;
    logic [63:0] w_hold_value_nxt;
    logic [7:0]  r_hold_addr;
    logic [7:0]  w_hold_addr_nxt;
    logic [3:0]  r_hold_reg;
    logic [3:0]  w_hold_reg_nxt;
    logic        w_is_mem_in;

    assign w_is_mem_in = control_signals_in[4] | control_signals_in[5];

    // FSM state, latency counter and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_hold_ctrl  <= 8'd0;
            r_hold_value <= 64'd0;
            r_hold_addr  <= 8'd0;
            r_hold_reg   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold_ctrl  <= w_hold_ctrl_nxt;
            r_hold_value <= w_hold_value_nxt;
            r_hold_addr  <= w_hold_addr_nxt;
            r_hold_reg   <= w_hold_reg_nxt;
        end
    end

    // Next-state logic: accept, count down, and select the committing op.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hold_ctrl_nxt  = r_hold_ctrl;
        w_hold_value_nxt = r_hold_value;
        w_hold_addr_nxt  = r_hold_addr;
        w_hold_reg_nxt   = r_hold_reg;
        w_commit         = 1'b0;
        w_op_ctrl        = control_signals_in;
        w_op_value       = value_in;
        w_op_addr        = address_in;
        w_op_reg         = reg_to_be_written_in;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem_in && MULTI_CYCLE) begin
                    w_hold_ctrl_nxt  = control_signals_in;
                    w_hold_value_nxt = value_in;
                    w_hold_addr_nxt  = address_in;
                    w_hold_reg_nxt   = reg_to_be_written_in;
                    w_cnt_nxt        = CNT_LOAD;
                    w_state_nxt      = ST_WAIT;
                end else begin
                    w_commit = 1'b1;
                end
            end
            ST_WAIT: begin
                // Inputs are ignored here; the latched op is what commits.
                w_op_ctrl  = r_hold_ctrl;
                w_op_value = r_hold_value;
                w_op_addr  = r_hold_addr;
                w_op_reg   = r_hold_reg;
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall_out = (r_state == ST_WAIT);
`else
    assign w_op_ctrl  = control_signals_in;
    assign w_op_value = value_in;
    assign w_op_addr  = address_in;
    assign w_op_reg   = reg_to_be_written_in;
    assign w_commit   = 1'b1;
    assign stall_out  = 1'b0;
`endif

    // Op decode: mem_write wins over mem_read when both are set.
    logic w_is_store;
    logic w_is_load;

    assign w_is_store = w_op_ctrl[5];
    assign w_is_load  = w_op_ctrl[4] & ~w_op_ctrl[5];

    logic [7:0]  r_ctrl_out;
    logic [63:0] r_value_out;
    logic [3:0]  r_reg_out;
    logic        r_rwe;
    logic [7:0]  w_ctrl_out_nxt;
    logic [63:0] w_value_out_nxt;
    logic [3:0]  w_reg_out_nxt;
    logic        w_rwe_nxt;

    // Output next-values: the result on commit, otherwise a bubble that
    // keeps value/reg but clears control and reg_write_en.
    always_comb begin
        w_ctrl_out_nxt  = 8'd0;
        w_value_out_nxt = r_value_out;
        w_reg_out_nxt   = r_reg_out;
        w_rwe_nxt       = 1'b0;
        if (w_commit) begin
            w_ctrl_out_nxt  = w_op_ctrl;
            w_value_out_nxt = w_is_load ? r_mem[w_op_addr] : w_op_value;
            w_reg_out_nxt   = w_op_reg;
            w_rwe_nxt       = w_is_store ? 1'b0 : w_op_ctrl[6];
        end else begin
            w_ctrl_out_nxt = 8'd0;
            w_rwe_nxt      = 1'b0;
        end
    end

    // Registered outputs to write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_out  <= 8'd0;
            r_value_out <= 64'd0;
            r_reg_out   <= 4'd0;
            r_rwe       <= 1'b0;
        end else begin
            r_ctrl_out  <= w_ctrl_out_nxt;
            r_value_out <= w_value_out_nxt;
            r_reg_out   <= w_reg_out_nxt;
            r_rwe       <= w_rwe_nxt;
        end
    end

    // Memory write, only at the commit edge of a store.
    always_ff @(posedge clk) begin
        if (w_commit && w_is_store) begin
            r_mem[w_op_addr] <= w_op_value;
        end
    end

    assign control_signals_out   = r_ctrl_out;
    assign value_out             = r_value_out;
    assign reg_to_be_written_out = r_reg_out;
    assign reg_write_en          = r_rwe;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined processor, sitting directly downstream of the ALU stage and upstream of write-back. Consumes the ALU's registered control byte, 64-bit result, 8-bit address and destination register. Performs loads and stores against a private 256 x 64-bit data memory, then presents a registered result to write-back. Holds the upstream pipeline via `stall_out` when a multi-cycle access is in flight.

## Interface
- `MEM_LATENCY`, default 3: cycles per load/store when `MEM_STAGE_WAIT_EN` is defined; legal range 1..15.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `control_signals_in` in 8: control byte from ALU.
  - [2:0] ALU opcode, [3] conditional branch, [7] jump: passed through untouched.
  - [4] mem_read.
  - [5] mem_write.
  - [6] reg_write.
- `value_in` in 64: ALU result; this is the store data for stores.
- `address_in` in 8: data-memory word address.
- `reg_to_be_written_in` in 4: destination register index.
- `control_signals_out` out 8: registered control byte to write-back.
- `value_out` out 64: load data for loads; `value_in` otherwise.
- `reg_to_be_written_out` out 4: registered destination register.
- `reg_write_en` out 1: registered `control_signals_in[6]` of the completing op.
- `stall_out` out 1: when high, upstream must hold all inputs stable.

## Operation
- Memory:
  - 256 words, indexed by `address_in`; no reset of contents.
  - Address is always in range because it is 8 bits wide; no wrap logic is needed.
- Op classes:
  - Store: ctrl[5]=1. Writes `value_in` to `mem[address_in]`.
  - Load: ctrl[4]=1 and ctrl[5]=0. Returns `mem[address_in]` on `value_out`.
  - Pass-through: everything else.
- If ctrl[4] and ctrl[5] are both set, the op is a store; ctrl[4] is ignored.
- A store always drives `reg_write_en`=0 regardless of ctrl[6]. `value_out` = `value_in`.
- FSM states: IDLE, WAIT.
  - IDLE: pass-through ops complete in 1 cycle.
  - IDLE with a load/store and effective latency > 1: latch ctrl, address, data and reg into holding registers; load counter with `MEM_LATENCY`-2; go to WAIT.
  - WAIT: `stall_out`=1, combinational from state. Inputs are ignored. Outputs present a bubble: ctrl out = 0, `reg_write_en`=0, value and reg hold their previous values.
  - WAIT with counter = 0: commit the access from the holding registers on this edge, drive the outputs, return to IDLE.
  - WAIT otherwise: decrement the counter.
- Memory is read and written only at the commit edge. A load directly after a store to the same address returns the stored value. No bypass is needed.
- Reset at any time:
  - State returns to IDLE; `stall_out`=0.
  - All outputs go to 0.
  - A pending store is discarded (memory unchanged).

## Timing
- Reset value of every output: 0.
- Pass-through latency: outputs update on the first rising edge after the inputs are presented (1 cycle).
- Load/store latency: N = `MEM_LATENCY` with the macro, 1 without.
  - The op is accepted at edge E.
  - `stall_out` is high for cycles E+1 .. E+N-1.
  - The result is visible after edge E+N-1.
  - `stall_out` drops in the same cycle the result appears.
- `stall_out` is never high in IDLE.
- Upstream must not change inputs while `stall_out`=1. When `stall_out` deasserts, the next op is accepted at the following edge.

## Configuration
- `MEM_STAGE_WAIT_EN` defined:
  - Multi-cycle access per `MEM_LATENCY` using the FSM and counter above.
- `MEM_STAGE_WAIT_EN` undefined:
  - Every op completes in 1 cycle.
  - The WAIT state, counter and holding registers are not built.
  - `stall_out` is tied to 0.
  - `MEM_LATENCY` is ignored.

## Test plan
- Pass-through: ctrl=8'h41, value=64'h1234, reg=4'd5 -> next cycle: ctrl out 8'h41, `value_out` 64'h1234, reg 5, `reg_write_en`=1, `stall_out`=0.
- Store then load, macro on, `MEM_LATENCY`=3:
  - Store 64'hDEAD_BEEF to addr 8'h10 -> `stall_out` high 2 cycles, `reg_write_en`=0.
  - Then load addr 8'h10 -> after 3 cycles `value_out`=64'hDEAD_BEEF, `reg_write_en`=1.
- Same store/load sequence, macro off -> each completes in 1 cycle, `stall_out` never asserts, same data returned.
- ctrl[4] and ctrl[5] both set at addr 8'hFF with value 64'h7 -> treated as a store: a later load of 8'hFF returns 64'h7; `reg_write_en`=0 on the store.
- Reset mid-operation: assert `rst_n`=0 during WAIT of a store of 64'h55 to addr 8'h20 -> `stall_out` and all outputs go to 0 immediately. A later load of 8'h20 returns the prior contents, not 64'h55.
- Input change during stall: alter `value_in` and `address_in` while `stall_out`=1 -> the committed access uses the values latched at acceptance.
